// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the RAM responder path
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_W = 4;

endpackage

// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - arbiter-to-RAM request/response bundle
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN,
        output ramWEN,
        output ramaddr,
        output ramstore,
        input  ramload,
        input  ramstate
    );

    modport slave (
        input  ramREN,
        input  ramWEN,
        input  ramaddr,
        input  ramstore,
        output ramload,
        output ramstate
    );

endinterface

// File: rtl/ram_responder_ram_array.sv
// rtl/ram_responder_ram_array.sv - DEPTH x 32 storage, async read, sync write, async clear
module ram_array
    import cpu_types_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - latency-modelled RAM responder: request decode, wait counter, storage
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 256
) (
    input logic             CLK,
    input logic             RST,
    ram_responder_if.slave  bus
);

    localparam int                   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0]          DEPTH_W = 30'(DEPTH);
    localparam logic [RAM_LAT_W-1:0] LAT_C   = RAM_LAT_W'(LAT);

    logic [RAM_LAT_W-1:0] r_cnt;
    logic                 r_ren;
    logic                 r_wen;
    word_t                r_addr;
    word_t                r_store;

    logic [RAM_LAT_W-1:0] w_cnt;
    logic [RAM_LAT_W-1:0] w_cnt_nxt;
    ramstate_t            w_state;
    logic                 w_is_read;
    logic                 w_same;
    logic                 w_addr_ok;
    logic                 w_we;
    word_t                w_rdata;

    assign w_is_read = bus.ramREN && !bus.ramWEN;
    assign w_addr_ok = (bus.ramaddr[1:0] == 2'b00) && (bus.ramaddr[31:2] < DEPTH_W);

    // Write data only identifies a write; a read stays the same request while ramstore wanders.
    assign w_same = (bus.ramREN == r_ren) && (bus.ramWEN == r_wen) &&
                    (bus.ramaddr == r_addr) &&
                    (w_is_read || (bus.ramstore == r_store));

    // A new request counts its first cycle as cnt==0, so ACCESS lands exactly LAT cycles later.
    always_comb begin
        w_cnt     = w_same ? r_cnt : '0;
        w_state   = FREE;
        w_cnt_nxt = '0;
        if (RST) begin
            w_state = FREE;
        end else if (!bus.ramREN && !bus.ramWEN) begin
            w_state = FREE;
        end else if (bus.ramREN && bus.ramWEN) begin
            w_state = ERROR;
        end else if (!w_addr_ok) begin
            w_state = ERROR;
        end else if (w_cnt < LAT_C) begin
            w_state = BUSY;
        end else begin
            w_state = ACCESS;
        end
        if (w_state == BUSY) begin
            w_cnt_nxt = w_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_store <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ren   <= bus.ramREN;
            r_wen   <= bus.ramWEN;
            r_addr  <= bus.ramaddr;
            r_store <= bus.ramstore;
        end
    end

    assign w_we = (w_state == ACCESS) && bus.ramWEN;

    ram_array #(
        .DEPTH (DEPTH)
    ) u_ram_array (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_we    (w_we),
        .i_waddr (bus.ramaddr[AW+1:2]),
        .i_wdata (bus.ramstore),
        .i_raddr (bus.ramaddr[AW+1:2]),
        .o_rdata (w_rdata)
    );

    assign bus.ramstate = w_state;
    assign bus.ramload  = ((w_state == ACCESS) && bus.ramREN) ? w_rdata : '0;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed scoreboard bench for ram_responder at LAT 0, 2 and 3
module tb_ram_responder;
    import cpu_types_pkg::*;

    typedef struct {
        int        dut;
        ramstate_t st;
        word_t     ld;
        string     tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    ram_responder_if if0 ();
    ram_responder_if if2 ();
    ram_responder_if if3 ();

    ram_responder #(.LAT(0), .DEPTH(256)) u_dut0 (.CLK(clk), .RST(rst), .bus(if0.slave));
    ram_responder #(.LAT(2), .DEPTH(256)) u_dut2 (.CLK(clk), .RST(rst), .bus(if2.slave));
    ram_responder #(.LAT(3), .DEPTH(256)) u_dut3 (.CLK(clk), .RST(rst), .bus(if3.slave));

    always #5 clk = ~clk;

    task automatic drive(input int d, input logic ren, input logic wen,
                         input word_t addr, input word_t store);
        if0.ramREN = 1'b0; if0.ramWEN = 1'b0; if0.ramaddr = '0; if0.ramstore = '0;
        if2.ramREN = 1'b0; if2.ramWEN = 1'b0; if2.ramaddr = '0; if2.ramstore = '0;
        if3.ramREN = 1'b0; if3.ramWEN = 1'b0; if3.ramaddr = '0; if3.ramstore = '0;
        case (d)
            0: begin if0.ramREN = ren; if0.ramWEN = wen; if0.ramaddr = addr; if0.ramstore = store; end
            2: begin if2.ramREN = ren; if2.ramWEN = wen; if2.ramaddr = addr; if2.ramstore = store; end
            default: begin if3.ramREN = ren; if3.ramWEN = wen; if3.ramaddr = addr; if3.ramstore = store; end
        endcase
    endtask

    task automatic push(input int d, input ramstate_t st, input word_t ld, input string tag);
        exp_t e;
        e.dut = d; e.st = st; e.ld = ld; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t      e;
        ramstate_t a_st;
        word_t     a_ld;
        e = sb.pop_front();
        case (e.dut)
            0:       begin a_st = if0.ramstate; a_ld = if0.ramload; end
            2:       begin a_st = if2.ramstate; a_ld = if2.ramload; end
            default: begin a_st = if3.ramstate; a_ld = if3.ramload; end
        endcase
        n_assert++;
        assert (a_st === e.st) else begin
            n_fail++;
            $error("FAIL %s ramstate: got %0d expected %0d", e.tag, a_st, e.st);
        end
        n_assert++;
        assert (a_ld === e.ld) else begin
            n_fail++;
            $error("FAIL %s ramload: got %h expected %h", e.tag, a_ld, e.ld);
        end
    endtask

    // One cycle: starts 1 unit after a rising edge, checks at the falling edge, ends after the next rising edge.
    task automatic cyc(input int d, input logic ren, input logic wen, input word_t addr,
                       input word_t store, input ramstate_t st, input word_t ld, input string tag);
        drive(d, ren, wen, addr, store);
        push(d, st, ld, tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_assert = 0;
        n_fail = 0;
        drive(2, 1'b0, 1'b0, '0, '0);

        repeat (2) @(posedge clk);
        #1;
        drive(2, 1'b1, 1'b0, 32'h10, '0);
        push(2, FREE, '0, "rst_hold_dut2");
        @(negedge clk);
        check_out();
        drive(0, 1'b1, 1'b0, 32'h0, '0);
        push(0, FREE, '0, "rst_hold_dut0");
        #1;
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(2, 1'b0, 1'b0, 32'h0, 32'h0, FREE, '0, "idle");

        cyc(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, BUSY,   '0, "wr10_b0");
        cyc(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, BUSY,   '0, "wr10_b1");
        cyc(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ACCESS, '0, "wr10_acc");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, BUSY,   '0, "rd10_b0");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, BUSY,   '0, "rd10_b1");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF, "rd10_acc");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, BUSY,   '0, "rd10_held_b0");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, BUSY,   '0, "rd10_held_b1");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF, "rd10_held_acc");

        cyc(2, 1'b1, 1'b1, 32'h0,   32'h0,        ERROR, '0, "err_both");
        cyc(2, 1'b1, 1'b0, 32'h3,   32'h0,        ERROR, '0, "err_misalign_rd");
        cyc(2, 1'b1, 1'b0, 32'h400, 32'h0,        ERROR, '0, "err_range_rd");
        cyc(2, 1'b0, 1'b1, 32'h12,  32'hBAD0BAD0, ERROR, '0, "err_misalign_wr");
        cyc(2, 1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, ERROR, '0, "err_range_wr");
        cyc(2, 1'b1, 1'b1, 32'h0,   32'hBAD0BAD0, ERROR, '0, "err_both_wr");

        cyc(2, 1'b1, 1'b0, 32'h0, 32'h0, BUSY,   '0, "rd0_b0");
        cyc(2, 1'b1, 1'b0, 32'h0, 32'h0, BUSY,   '0, "rd0_b1");
        cyc(2, 1'b1, 1'b0, 32'h0, 32'h0, ACCESS, '0, "rd0_acc");

        cyc(2, 1'b0, 1'b1, 32'h3FC, 32'hCAFE0001, BUSY,   '0, "wr3fc_b0");
        cyc(2, 1'b0, 1'b1, 32'h3FC, 32'hCAFE0001, BUSY,   '0, "wr3fc_b1");
        cyc(2, 1'b0, 1'b1, 32'h3FC, 32'hCAFE0001, ACCESS, '0, "wr3fc_acc");
        cyc(2, 1'b1, 1'b0, 32'h3FC, 32'h0, BUSY,   '0, "rd3fc_b0");
        cyc(2, 1'b1, 1'b0, 32'h3FC, 32'h0, BUSY,   '0, "rd3fc_b1");
        cyc(2, 1'b1, 1'b0, 32'h3FC, 32'h0, ACCESS, 32'hCAFE0001, "rd3fc_acc");

        cyc(2, 1'b1, 1'b0, 32'h10, 32'h11111111, BUSY,   '0, "rd_store_wiggle_b0");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h22222222, BUSY,   '0, "rd_store_wiggle_b1");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h33333333, ACCESS, 32'hDEADBEEF, "rd_store_wiggle_acc");

        cyc(2, 1'b0, 1'b1, 32'h14, 32'h00000001, BUSY,   '0, "wr14_b0");
        cyc(2, 1'b0, 1'b1, 32'h14, 32'h00000002, BUSY,   '0, "wr14_restart_b0");
        cyc(2, 1'b0, 1'b1, 32'h14, 32'h00000002, BUSY,   '0, "wr14_restart_b1");
        cyc(2, 1'b0, 1'b1, 32'h14, 32'h00000002, ACCESS, '0, "wr14_acc");
        cyc(2, 1'b1, 1'b0, 32'h14, 32'h0, BUSY,   '0, "rd14_b0");
        cyc(2, 1'b1, 1'b0, 32'h14, 32'h0, BUSY,   '0, "rd14_b1");
        cyc(2, 1'b1, 1'b0, 32'h14, 32'h0, ACCESS, 32'h00000002, "rd14_acc");

        cyc(0, 1'b1, 1'b0, 32'h0, 32'h0, ACCESS, '0, "lat0_rd0_c0");
        cyc(0, 1'b1, 1'b0, 32'h0, 32'h0, ACCESS, '0, "lat0_rd0_c1");
        cyc(0, 1'b1, 1'b0, 32'h0, 32'h0, ACCESS, '0, "lat0_rd0_c2");
        cyc(0, 1'b0, 1'b1, 32'h4, 32'hA5A5A5A5, ACCESS, '0, "lat0_wr4");
        cyc(0, 1'b1, 1'b0, 32'h4, 32'h0, ACCESS, 32'hA5A5A5A5, "lat0_rd4_b2b");
        cyc(0, 1'b1, 1'b0, 32'h3, 32'h0, ERROR, '0, "lat0_err_misalign");

        cyc(3, 1'b1, 1'b0, 32'h20, 32'h0, BUSY,   '0, "lat3_rd20_b0");
        cyc(3, 1'b1, 1'b0, 32'h20, 32'h0, BUSY,   '0, "lat3_rd20_b1");
        cyc(3, 1'b1, 1'b0, 32'h24, 32'h0, BUSY,   '0, "lat3_rd24_b0");
        cyc(3, 1'b1, 1'b0, 32'h24, 32'h0, BUSY,   '0, "lat3_rd24_b1");
        cyc(3, 1'b1, 1'b0, 32'h24, 32'h0, BUSY,   '0, "lat3_rd24_b2");
        cyc(3, 1'b1, 1'b0, 32'h24, 32'h0, ACCESS, '0, "lat3_rd24_acc");

        cyc(2, 1'b0, 1'b1, 32'h8, 32'h12345678, BUSY, '0, "wr8_b0");
        cyc(2, 1'b0, 1'b1, 32'h8, 32'h12345678, BUSY, '0, "wr8_b1");
        drive(2, 1'b0, 1'b1, 32'h8, 32'h12345678);
        push(2, ACCESS, '0, "wr8_acc");
        @(negedge clk);
        check_out();
        #2;
        rst = 1'b1;
        drive(2, 1'b1, 1'b0, 32'h8, '0);
        push(2, FREE, '0, "rst_in_access");
        #1;
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2, 1'b1, 1'b0, 32'h8, 32'h0, BUSY,   '0, "rd8_after_rst_b0");
        cyc(2, 1'b1, 1'b0, 32'h8, 32'h0, BUSY,   '0, "rd8_after_rst_b1");
        cyc(2, 1'b1, 1'b0, 32'h8, 32'h0, ACCESS, '0, "rd8_after_rst_acc");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, BUSY,   '0, "rd10_cleared_b0");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, BUSY,   '0, "rd10_cleared_b1");
        cyc(2, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, '0, "rd10_cleared_acc");
        cyc(2, 1'b0, 1'b0, 32'h0, 32'h0, FREE, '0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
